// File: rtl/pc_ctrl_pkg.sv
// Shared encodings for the exception/PC-source controller: mux select codes, FSM states,
// exception causes and the fixed exception vector bytes.
package pc_ctrl_pkg;

    localparam logic [2:0] PcSrcAlu       = 3'b000;
    localparam logic [2:0] PcSrcAluOut    = 3'b001;
    localparam logic [2:0] PcSrcInstr     = 3'b010;
    localparam logic [2:0] PcSrcEpc       = 3'b011;
    localparam logic [2:0] PcSrcExcTarget = 3'b100;
    localparam logic [2:0] PcSrcVecOpcode = 3'b101;
    localparam logic [2:0] PcSrcVecOvf    = 3'b110;
    localparam logic [2:0] PcSrcVecDiv0   = 3'b111;

    localparam logic [7:0] VecOpcode = 8'd253;
    localparam logic [7:0] VecOvf    = 8'd254;
    localparam logic [7:0] VecDiv0   = 8'd255;

    localparam int unsigned CntW = 3;

    typedef enum logic [2:0] {
        StIdle,
        StSaveEpc,
        StLoadVec,
        StMemWait,
        StJump
    } state_e;

    typedef enum logic [1:0] {
        CauseNone   = 2'b00,
        CauseOpcode = 2'b01,
        CauseOvf    = 2'b10,
        CauseDiv0   = 2'b11
    } cause_e;

    // Opcode beats overflow beats divide-by-zero.
    function automatic cause_e prio_cause(input logic opc, input logic ovf, input logic div0);
        if (opc) begin
            return CauseOpcode;
        end else if (ovf) begin
            return CauseOvf;
        end else if (div0) begin
            return CauseDiv0;
        end
        return CauseNone;
    endfunction

    function automatic logic [2:0] vec_pcsource(input cause_e cause);
        logic [2:0] sel;
        unique case (cause)
            CauseOpcode: sel = PcSrcVecOpcode;
            CauseOvf:    sel = PcSrcVecOvf;
            CauseDiv0:   sel = PcSrcVecDiv0;
            default:     sel = PcSrcAlu;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Down-counter that times the exception vector memory read; done flags a zero count.
module mem_wait_counter
    import pc_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            i_load,
    input  logic [CntW-1:0] i_load_val,
    input  logic            i_dec,
    output logic            o_done
);

    logic [CntW-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/exception_pc_ctrl.sv
// PC source / exception sequencer: forwards normal PC updates while idle and, on an exception,
// saves EPC, loads the vector address, reads the handler byte and jumps to it.
module exception_pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pc_req,
    input  logic [1:0]  pc_src_req,
    input  logic        cond_ok,
    input  logic        exc_opcode,
    input  logic        exc_ovf,
    input  logic        exc_div0,
    input  logic [7:0]  mem_byte,
    output logic [2:0]  pcsource,
    output logic        pc_write,
    output logic        epc_write,
    output logic        mem_read,
    output logic [31:0] exc_target,
    output logic        busy,
    output logic [1:0]  exc_cause
);

    state_e     r_state;
    cause_e     r_cause;
    logic [2:0] r_pcsource;
    logic       r_pc_write;
    logic       r_epc_write;
    logic       r_mem_read;
    logic       r_busy;
    logic [7:0] r_vec_byte;

    logic       w_exc;
    logic       w_cnt_load;
    logic       w_cnt_dec;
    logic       w_cnt_done;
    logic       w_norm_write;

    assign w_exc        = exc_opcode | exc_ovf | exc_div0;
    // The branch condition only gates ALUOut; other sources load unconditionally.
    assign w_norm_write = pc_req && ((pc_src_req != 2'b01) || cond_ok);
    assign w_cnt_load   = (r_state == StLoadVec);
    assign w_cnt_dec    = (r_state == StMemWait) && !w_cnt_done;

    mem_wait_counter u_mem_wait_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_cnt_load),
        .i_load_val (CntW'(MEM_LATENCY - 1)),
        .i_dec      (w_cnt_dec),
        .o_done     (w_cnt_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_cause     <= CauseNone;
            r_pcsource  <= PcSrcAlu;
            r_pc_write  <= 1'b0;
            r_epc_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_busy      <= 1'b0;
            r_vec_byte  <= '0;
        end else begin
            // Strobes are single-cycle unless a state re-asserts them.
            r_pc_write  <= 1'b0;
            r_epc_write <= 1'b0;
            r_mem_read  <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_exc) begin
                        r_state     <= StSaveEpc;
                        r_epc_write <= 1'b1;
                        r_busy      <= 1'b1;
                        r_cause     <= prio_cause(exc_opcode, exc_ovf, exc_div0);
                    end else if (w_norm_write) begin
                        r_pc_write <= 1'b1;
                        r_pcsource <= {1'b0, pc_src_req};
                    end
                end
                StSaveEpc: begin
                    r_state    <= StLoadVec;
                    r_pc_write <= 1'b1;
                    r_pcsource <= vec_pcsource(r_cause);
                end
                StLoadVec: begin
                    r_state    <= StMemWait;
                    r_mem_read <= 1'b1;
                end
                StMemWait: begin
                    if (w_cnt_done) begin
                        r_state    <= StJump;
                        r_pc_write <= 1'b1;
                        r_pcsource <= PcSrcExcTarget;
                        r_vec_byte <= mem_byte;
                    end else begin
                        r_mem_read <= 1'b1;
                    end
                end
                StJump: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign pcsource   = r_pcsource;
    assign pc_write   = r_pc_write;
    assign epc_write  = r_epc_write;
    assign mem_read   = r_mem_read;
    assign busy       = r_busy;
    assign exc_target = {24'h000000, r_vec_byte};
    assign exc_cause  = r_cause;

endmodule

// File: tb/tb_exception_pc_ctrl.sv
// Bench for exception_pc_ctrl: directed vectors, a sequence-position model checked every cycle,
// and literal expectations at key points.
module tb_exception_pc_ctrl;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        pc_req = 1'b0;
    logic [1:0]  pc_src_req = 2'b00;
    logic        cond_ok = 1'b0;
    logic        exc_opcode = 1'b0;
    logic        exc_ovf = 1'b0;
    logic        exc_div0 = 1'b0;
    logic [7:0]  mem_byte = 8'h00;
    logic [2:0]  pcsource;
    logic        pc_write;
    logic        epc_write;
    logic        mem_read;
    logic [31:0] exc_target;
    logic        busy;
    logic [1:0]  exc_cause;

    int n_checks = 0;
    int n_errors = 0;

    exception_pc_ctrl #(.MEM_LATENCY(L)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pc_req     (pc_req),
        .pc_src_req (pc_src_req),
        .cond_ok    (cond_ok),
        .exc_opcode (exc_opcode),
        .exc_ovf    (exc_ovf),
        .exc_div0   (exc_div0),
        .mem_byte   (mem_byte),
        .pcsource   (pcsource),
        .pc_write   (pc_write),
        .epc_write  (epc_write),
        .mem_read   (mem_read),
        .exc_target (exc_target),
        .busy       (busy),
        .exc_cause  (exc_cause)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: -1 when idle, otherwise the number of cycles since the exception was taken.
    int          m_pos = -1;
    logic        m_pcw = 0, m_epc = 0, m_mr = 0, m_busy = 0;
    logic [2:0]  m_pcs = 0;
    logic [1:0]  m_cause = 0;
    logic [31:0] m_tgt = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pos = -1; m_pcw = 0; m_epc = 0; m_mr = 0; m_busy = 0;
            m_pcs = 0; m_cause = 0; m_tgt = 0;
        end else if (m_pos < 0) begin
            m_pcw = 0; m_epc = 0; m_mr = 0;
            if (exc_opcode || exc_ovf || exc_div0) begin
                m_cause = exc_opcode ? 2'd1 : (exc_ovf ? 2'd2 : 2'd3);
                m_pos = 0; m_epc = 1; m_busy = 1;
            end else if (pc_req && (pc_src_req != 2'd1 || cond_ok)) begin
                m_pcw = 1; m_pcs = {1'b0, pc_src_req};
            end
        end else begin
            m_pos++;
            m_pcw = 0; m_epc = 0; m_mr = 0;
            if (m_pos == 1) begin
                m_pcw = 1; m_pcs = 3'd4 + {1'b0, m_cause};
            end else if (m_pos <= L + 1) begin
                m_mr = 1;
            end else if (m_pos == L + 2) begin
                m_pcw = 1; m_pcs = 3'd4; m_tgt = {24'h0, mem_byte};
            end else begin
                m_busy = 0; m_pos = -1;
            end
        end
    end

    always @(negedge clk) begin
        chk("pc_write", 32'(pc_write), 32'(m_pcw));
        chk("epc_write", 32'(epc_write), 32'(m_epc));
        chk("mem_read", 32'(mem_read), 32'(m_mr));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("pcsource", 32'(pcsource), 32'(m_pcs));
        chk("exc_cause", 32'(exc_cause), 32'(m_cause));
        chk("exc_target", exc_target, m_tgt);
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic clr();
        pc_req = 0; pc_src_req = 0; cond_ok = 0;
        exc_opcode = 0; exc_ovf = 0; exc_div0 = 0;
    endtask

    int busy_cnt, mr_cnt, epc_cnt;

    initial begin
        #1 reset_n = 0;
        cyc(); cyc();
        chk("rst_pcsource", 32'(pcsource), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_exc_target", exc_target, 32'd0);
        reset_n = 1;

        // Normal update from Instruction.
        pc_req = 1; pc_src_req = 2'b10;
        cyc(); clr();
        chk("instr_pcw", 32'(pc_write), 32'd1);
        chk("instr_pcs", 32'(pcsource), 32'd2);
        chk("instr_busy", 32'(busy), 32'd0);

        // Conditional branch via ALUOut.
        pc_req = 1; pc_src_req = 2'b01; cond_ok = 0;
        cyc();
        chk("br_nt_pcw", 32'(pc_write), 32'd0);
        chk("br_nt_pcs_hold", 32'(pcsource), 32'd2);
        cond_ok = 1;
        cyc();
        chk("br_t_pcw", 32'(pc_write), 32'd1);
        chk("br_t_pcs", 32'(pcsource), 32'd1);
        pc_src_req = 2'b11; cond_ok = 0;
        cyc(); clr();
        chk("epc_src_pcs", 32'(pcsource), 32'd3);
        cyc();
        chk("idle_pcw_low", 32'(pc_write), 32'd0);

        // Overflow exception, vector byte 0x3C.
        exc_ovf = 1; mem_byte = 8'h3C;
        busy_cnt = 0; mr_cnt = 0; epc_cnt = 0;
        for (int c = 1; c <= 8; c++) begin
            cyc(); clr();
            busy_cnt += int'(busy); mr_cnt += int'(mem_read); epc_cnt += int'(epc_write);
            if (c == 1) chk("ovf_epc", 32'(epc_write), 32'd1);
            if (c == 2) chk("ovf_vec_pcs", 32'(pcsource), 32'd6);
            if (c == 2) chk("ovf_vec_pcw", 32'(pc_write), 32'd1);
            if (c == 5) chk("ovf_jump_pcs", 32'(pcsource), 32'd4);
            if (c == 5) chk("ovf_target", exc_target, 32'h0000003C);
        end
        chk("ovf_busy_cycles", 32'(busy_cnt), 32'd5);
        chk("ovf_mr_cycles", 32'(mr_cnt), 32'd2);
        chk("ovf_epc_cycles", 32'(epc_cnt), 32'd1);
        chk("ovf_cause", 32'(exc_cause), 32'd2);

        // Opcode + div0 + pc_req together.
        exc_opcode = 1; exc_div0 = 1; pc_req = 1; pc_src_req = 2'b00;
        cyc(); clr();
        chk("pri_no_pcw", 32'(pc_write), 32'd0);
        chk("pri_cause", 32'(exc_cause), 32'd1);
        cyc();
        chk("pri_vec_pcs", 32'(pcsource), 32'd5);
        repeat (5) cyc();

        // div0 pulse during MEM_WAIT of an overflow sequence is dropped.
        exc_ovf = 1; mem_byte = 8'h81;
        epc_cnt = 0;
        for (int c = 1; c <= 10; c++) begin
            cyc(); clr();
            if (c == 3) exc_div0 = 1;
            epc_cnt += int'(epc_write);
        end
        chk("ign_epc_cycles", 32'(epc_cnt), 32'd1);
        chk("ign_cause", 32'(exc_cause), 32'd2);
        chk("ign_target", exc_target, 32'h00000081);

        // Reset in MEM_WAIT.
        exc_div0 = 1;
        cyc(); clr();
        cyc();
        chk("div0_vec_pcs", 32'(pcsource), 32'd7);
        cyc();
        chk("div0_in_memwait", 32'(mem_read), 32'd1);
        #2 reset_n = 0;
        #1;
        chk("arst_pcs", 32'(pcsource), 32'd0);
        chk("arst_mr", 32'(mem_read), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_cause", 32'(exc_cause), 32'd0);
        chk("arst_target", exc_target, 32'd0);
        cyc();
        reset_n = 1; pc_req = 1; pc_src_req = 2'b00;
        cyc(); clr();
        chk("post_rst_pcw", 32'(pc_write), 32'd1);
        chk("post_rst_pcs", 32'(pcsource), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        repeat (3) cyc();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/exception_pc_ctrl.md
EXCEPTION_PC_CTRL -- requirements
Module: exception_pc_ctrl

Interface
REQ-001 Parameter MEM_LATENCY, default 2, SHALL set the memory read wait in cycles (range 1..7).
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 pc_req  in  1  main control requests a normal PC update this cycle.
REQ-005 pc_src_req  in  2  requested source: 00 ALU, 01 ALUOut, 10 Instruction, 11 EPC.
REQ-006 cond_ok  in  1  branch condition true; qualifies only source 01.
REQ-007 exc_opcode, exc_ovf, exc_div0  in  1 each  exception flags, sampled only in IDLE.
REQ-008 mem_byte  in  8  byte returned by memory during the vector read.
REQ-009 pcsource  out  3  select code for the PC source mux.
REQ-010 pc_write  out  1  PC register load enable.
REQ-011 epc_write  out  1  EPC register load enable (EPC <= PC-4, computed outside this block).
REQ-012 mem_read  out  1  memory read strobe, address taken from PC.
REQ-013 exc_target  out  32  zero-extended captured vector byte; feeds mux input 4.
REQ-014 busy  out  1  high in every state except IDLE; main control stalls while high.
REQ-015 exc_cause  out  2  00 none, 01 opcode, 10 overflow, 11 div-by-zero; held until next exception.

Function
REQ-016 Outputs SHALL be registered (Moore); no combinational input-to-output path.
REQ-017 States SHALL be IDLE, SAVE_EPC, LOAD_VEC, MEM_WAIT, JUMP.
REQ-018 IDLE, no exception, pc_req=1: next cycle pc_write=1 for one cycle with pcsource = zero-extended pc_src_req; for 01, pc_write=1 only if cond_ok=1.
REQ-019 IDLE, any exception flag high: SHALL go to SAVE_EPC; a same-cycle pc_req SHALL be dropped (no pc_write).
REQ-020 Priority SHALL be opcode > overflow > div-by-zero; exc_cause latched on entry to SAVE_EPC.
REQ-021 SAVE_EPC (1 cycle): epc_write=1, pc_write=0.
REQ-022 LOAD_VEC (1 cycle): pc_write=1, pcsource = 101 (opcode, 253), 110 (overflow, 254), 111 (div0, 255).
REQ-023 MEM_WAIT: mem_read=1 for exactly MEM_LATENCY cycles; mem_byte captured into exc_target[7:0] on the last cycle; exc_target[31:8]=0.
REQ-024 JUMP (1 cycle): pc_write=1, pcsource=100; then IDLE.
REQ-025 Exception flags and pc_req while busy=1 SHALL be ignored, not queued.
REQ-026 Exception entry to first IDLE cycle SHALL take exactly MEM_LATENCY+3 cycles.
REQ-027 Outside active strobes, pcsource SHALL hold its last driven value; pc_write, epc_write, mem_read SHALL be 0.

Reset
REQ-028 reset_n low SHALL immediately force state IDLE, pcsource 000, pc_write/epc_write/mem_read/busy 0, exc_target 0, exc_cause 00, counter 0.
REQ-029 Reset asserted mid-sequence SHALL abort it; no stale strobe after release.
REQ-030 First active edge after reset_n rises SHALL behave as IDLE.

Structure
REQ-031 Package pc_ctrl_pkg SHALL hold pcsource codes (000..111), state enum, cause codes, vector constants 253/254/255.
REQ-032 Sub-module mem_wait_counter (load, decrement, done) SHALL implement MEM_WAIT timing.

Verification
REQ-033 pc_req=1, pc_src_req=10 in IDLE -> next cycle pc_write=1, pcsource=010, busy=0.
REQ-034 pc_src_req=01, cond_ok=0 -> pc_write stays 0; cond_ok=1 -> pc_write=1, pcsource=001.
REQ-035 exc_ovf=1, MEM_LATENCY=2, mem_byte=0x3C -> epc_write; pcsource=110 with pc_write; 2 cycles mem_read; pcsource=100, exc_target=0x0000003C; busy 5 cycles; exc_cause=10.
REQ-036 exc_opcode=exc_div0=pc_req=1 same cycle -> cause 01, pcsource 101 in LOAD_VEC, no normal pc_write.
REQ-037 exc_div0 pulsed during MEM_WAIT of prior exception -> ignored; single sequence, cause unchanged.
REQ-038 reset_n low in MEM_WAIT -> all outputs 0 immediately; after release, pc_req=1, pc_src_req=00 -> pcsource=000 with pc_write.
